pipe_io_ctrl: RTL and testbench

PIPE_IO_CTRL -- requirements
Module: pipe_io_ctrl

---
 rtl/pipe_io_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_io_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_io_ctrl.sv
// Memory-mapped I/O block for the MEM stage: output latches, synchronised inputs,
// and (with PIPE_IO_IRQ_EN defined) input change flags with a level interrupt.
module pipe_io_ctrl #(
  parameter int unsigned NIN    = 2,
  parameter int unsigned NOUT   = 4,
  parameter int unsigned PW     = 32,
  parameter logic [3:0]  IO_TAG = 4'hC
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [31:0]          rdata,
  input  logic [NIN*PW-1:0]    in_port,
  output logic [NOUT*PW-1:0]   out_port,
  output logic                 irq
);

  logic                w_sel;
  logic                w_wr;
  logic [4:0]          w_off;
  logic [31:0]         w_rd_val;
  logic                w_unused;

  logic [NOUT*PW-1:0]  r_out;
  logic [NIN*PW-1:0]   r_sync1;
  logic [NIN*PW-1:0]   r_sync2;
  logic [31:0]         r_rdata;

  assign w_sel    = (addr[31:28] == IO_TAG);
  assign w_off    = addr[6:2];
  assign w_wr     = we & w_sel;
  assign w_unused = ^{addr[27:7], addr[1:0], wdata};

  assign out_port = r_out;
  assign rdata    = r_rdata;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_out <= '0;
    end else if (w_wr) begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        if (w_off == 5'(k)) r_out[k*PW +: PW] <= wdata[PW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIPE_IO_IRQ_EN
  logic [NIN*PW-1:0]   r_prev;
  logic [NIN-1:0]      r_chg;
  logic [NIN-1:0]      r_ien;
  logic                r_irq;
  logic [NIN-1:0]      w_chg_set;
  logic [NIN-1:0]      w_chg_clr;

  always_comb begin
    w_chg_set = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      w_chg_set[k] = (r_sync2[k*PW +: PW] != r_prev[k*PW +: PW]);
    end
  end

  assign w_chg_clr = (w_wr && (w_off == 5'd16)) ? wdata[NIN-1:0] : '0;

  // Set is OR-ed after the clear mask so a coincident change is never lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_prev <= '0;
      r_chg  <= '0;
      r_ien  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      r_chg  <= (r_chg & ~w_chg_clr) | w_chg_set;
      r_irq  <= |(r_chg & r_ien);
      if (w_wr && (w_off == 5'd17)) r_ien <= wdata[NIN-1:0];
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
      if (w_off == 5'(k)) w_rd_val = 32'(r_out[k*PW +: PW]);
    end
    for (int unsigned k = 0; k < NIN; k++) begin
      if (w_off == 5'(8 + k)) w_rd_val = 32'(r_sync2[k*PW +: PW]);
    end
`ifdef PIPE_IO_IRQ_EN
    if (w_off == 5'd16) w_rd_val = 32'(r_chg);
    if (w_off == 5'd17) w_rd_val = 32'(r_ien);
`endif
    if (!w_sel) w_rd_val = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= w_rd_val;
    end
  end

endmodule

// File: tb/tb_pipe_io_ctrl.sv
// Self-checking bench for pipe_io_ctrl: register-map model compared every cycle,
// plus directed literal expectations. Covers PIPE_IO_IRQ_EN when defined.
module tb_pipe_io_ctrl;
  localparam int NIN  = 2;
  localparam int NOUT = 4;
  localparam int PW   = 32;

  logic                clock = 1'b0;
  logic                resetn;
  logic [31:0]         addr, wdata, rdata;
  logic                we, re, irq;
  logic [NIN*PW-1:0]   in_port;
  logic [NOUT*PW-1:0]  out_port;
  logic                cmp_en;

  int checks = 0;
  int passes = 0;

  pipe_io_ctrl #(.NIN(NIN), .NOUT(NOUT), .PW(PW), .IO_TAG(4'hC)) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  // Behavioural model: register map plus a delay line of sampled inputs.
  logic [31:0]        m_out [NOUT];
  logic [31:0]        m_rdata;
  logic               m_irq;
  logic [NIN*PW-1:0]  m_d1, m_d2;
`ifdef PIPE_IO_IRQ_EN
  logic [NIN*PW-1:0]  m_d3;
  logic [NIN-1:0]     m_chg, m_ien;

  function automatic logic [NIN-1:0] m_set();
    logic [NIN-1:0] s;
    s = '0;
    for (int k = 0; k < NIN; k++) s[k] = (m_d2[k*PW +: PW] != m_d3[k*PW +: PW]);
    return s;
  endfunction
`endif

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int off;
    logic [31:0] v;
    off = int'(a[6:2]);
    v = '0;
    if (a[31:28] == 4'hC) begin
      if (off < NOUT) v = m_out[off];
      if (off >= 8 && off < 8 + NIN) v = 32'(m_d2[(off-8)*PW +: PW]);
`ifdef PIPE_IO_IRQ_EN
      if (off == 16) v = 32'(m_chg);
      if (off == 17) v = 32'(m_ien);
`endif
    end
    return v;
  endfunction

  function automatic logic [NOUT*PW-1:0] m_out_pack();
    logic [NOUT*PW-1:0] p;
    for (int k = 0; k < NOUT; k++) p[k*PW +: PW] = m_out[k][PW-1:0];
    return p;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NOUT; k++) m_out[k] <= '0;
      m_rdata <= '0;
      m_irq   <= 1'b0;
      m_d1    <= '0;
      m_d2    <= '0;
`ifdef PIPE_IO_IRQ_EN
      m_d3    <= '0;
      m_chg   <= '0;
      m_ien   <= '0;
`endif
    end else begin
      if (re) m_rdata <= m_read(addr);
      if (we && addr[31:28] == 4'hC && int'(addr[6:2]) < NOUT)
        m_out[int'(addr[6:2])] <= 32'(wdata[PW-1:0]);
      m_d1 <= in_port;
      m_d2 <= m_d1;
`ifdef PIPE_IO_IRQ_EN
      m_d3  <= m_d2;
      m_irq <= |(m_chg & m_ien);
      m_chg <= (m_chg & ~((we && addr[31:28] == 4'hC && addr[6:2] == 5'd16) ? wdata[NIN-1:0] : '0))
               | m_set();
      if (we && addr[31:28] == 4'hC && addr[6:2] == 5'd17) m_ien <= wdata[NIN-1:0];
`endif
    end
  end

  always @(negedge clock) begin
    if (cmp_en && resetn) begin
      chk("cyc_out_port", out_port, m_out_pack());
      chk("cyc_rdata", rdata, m_rdata);
      chk("cyc_irq", irq, m_irq);
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    @(negedge clock); #1;
    addr = a; wdata = d; we = w; re = r;
    @(posedge clock); #1;
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0; in_port = '0; cmp_en = 1'b0;
    #3 resetn = 1'b0;
    #1;
    chk("rst_out_port", out_port, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", irq, 0);
    repeat (2) @(negedge clock);
    #1 resetn = 1'b1;
    cmp_en = 1'b1;

    op(32'hC000_0004, 32'h0000_00A5, 1, 0);
    chk("out1_write", out_port[63:32], 32'h0000_00A5);
    op(32'hC000_0004, 32'h0, 0, 1);
    chk("out1_read", rdata, 32'h0000_00A5);
    op(32'hC000_0000, 32'hDEAD_BEEF, 1, 0);
    op(32'hC000_000C, 32'h1234_5678, 1, 0);
    op(32'hC000_0014, 32'hFFFF_FFFF, 1, 0);
    op(32'hC000_0014, 32'h0, 0, 1);
    chk("out5_read_zero", rdata, 32'h0);
    op(32'hC000_0004, 32'h0, 0, 1);
    op(32'h4000_0000, 32'h0, 0, 1);
    chk("unsel_read_zero", rdata, 32'h0);
    op(32'h4000_0000, 32'hFFFF_FFFF, 1, 0);
    chk("unsel_write_ign", out_port, {32'h1234_5678, 32'h0, 32'h0000_00A5, 32'hDEAD_BEEF});
    op(32'hC000_0004, 32'h0000_0077, 1, 1);
    chk("rw_same_rdata", rdata, 32'h0000_00A5);
    chk("rw_same_out", out_port[63:32], 32'h0000_0077);

    @(negedge clock); #1;
    in_port = 64'h0000_CAFE_0000_1234;
    addr = 32'hC000_0020; re = 1'b1;
    @(posedge clock); #1 re = 1'b0;
    chk("in0_early", rdata, 32'h0);
    @(negedge clock);
    op(32'hC000_0020, 32'h0, 0, 1);
    chk("in0_synced", rdata, 32'h0000_1234);
    op(32'hC000_0024, 32'h0, 0, 1);
    chk("in1_synced", rdata, 32'h0000_CAFE);
    op(32'hC000_0020, 32'hFFFF, 1, 0);
    op(32'hC000_0020, 32'h0, 0, 1);
    chk("in0_write_ign", rdata, 32'h0000_1234);
    chk("in_write_out", out_port, {32'h1234_5678, 32'h0, 32'h0000_0077, 32'hDEAD_BEEF});

`ifdef PIPE_IO_IRQ_EN
    op(32'hC000_0040, 32'h3, 1, 0);
    op(32'hC000_0044, 32'h1, 1, 0);
    repeat (2) @(posedge clock);
    #1 chk("irq_idle", irq, 0);
    op(32'hC000_0040, 32'h0, 0, 1);
    chk("chg_clear", rdata, 32'h0);
    @(negedge clock); #1 in_port[0] = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk("irq_lag", irq, 0);
    @(posedge clock); #1 chk("irq_set", irq, 1);
    op(32'hC000_0040, 32'h0, 0, 1);
    chk("chg_read", rdata, 32'h1);
    op(32'hC000_0040, 32'h1, 1, 0);
    chk("irq_hold", irq, 1);
    @(posedge clock); #1 chk("irq_cleared", irq, 0);
    @(negedge clock); #1 in_port[0] = 1'b0;
    @(negedge clock);
    op(32'hC000_0040, 32'h1, 1, 0);
    op(32'hC000_0040, 32'h0, 0, 1);
    chk("set_wins", rdata, 32'h1);
    op(32'hC000_0044, 32'h0, 0, 1);
    chk("ien_read", rdata, 32'h1);
`else
    op(32'hC000_0040, 32'hFF, 1, 0);
    op(32'hC000_0044, 32'hFF, 1, 0);
    op(32'hC000_0004, 32'h0, 0, 1);
    op(32'hC000_0040, 32'h0, 0, 1);
    chk("chg_absent", rdata, 32'h0);
    op(32'hC000_0004, 32'h0, 0, 1);
    op(32'hC000_0044, 32'h0, 0, 1);
    chk("ien_absent", rdata, 32'h0);
    chk("irq_absent", irq, 0);
`endif

    op(32'hC000_0000, 32'hFFFF_FFFF, 1, 0);
    op(32'hC000_0000, 32'h0, 0, 1);
    chk("out0_ones", rdata, 32'hFFFF_FFFF);
`ifdef PIPE_IO_IRQ_EN
    chk("irq_before_rst", irq, 1);
`endif
    @(negedge clock); #1;
    addr = 32'hC000_0008; wdata = 32'h55; we = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_out", out_port, 0);
    chk("async_rst_rdata", rdata, 0);
    chk("async_rst_irq", irq, 0);
    we = 1'b0;
    repeat (2) @(negedge clock);
    #1 resetn = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_rst_out", out_port, 0);
`ifdef PIPE_IO_IRQ_EN
    op(32'hC000_0040, 32'h0, 0, 1);
    chk("post_rst_chg", rdata, 32'h3);
`else
    op(32'hC000_0024, 32'h0, 0, 1);
    chk("post_rst_in1", rdata, 32'h0000_CAFE);
`endif
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
